shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_if.sv | 24 ++
 rtl/shift_arbiter.sv | 78 +++++++
 tb/tb_shift_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// rtl/shift_arbiter_if.sv - requester/response bundle for the shared shifter
interface shift_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [7:0]         req_valid;
  logic [8*WIDTH-1:0] req_data;
  logic [39:0]        req_shamt;
  logic [7:0]         req_arith;
  logic [7:0]         req_ready;
  logic               resp_valid;
  logic [WIDTH-1:0]   resp_data;
  logic [2:0]         resp_id;
  logic               resp_ready;

  modport master (
    output req_valid, req_data, req_shamt, req_arith, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_arith, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter over 8 requesters sharing one right shifter
module shift_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  shift_arbiter_if.slave    bus,
  output logic [15:0]       accept_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       gidx;
  logic [2:0]       idx;
  logic             found;
  logic             slot_free;
  logic [7:0]       grant;
  logic [WIDTH-1:0] op;
  logic [WIDTH-1:0] shifted;
  logic [4:0]       sh;
  logic             ar;
  logic [WIDTH-1:0] data_q;
  logic [2:0]       id_q;

  // Scan starts at ptr and wraps naturally through the 3-bit index.
  always_comb begin
    slot_free = (state == EMPTY) || bus.resp_ready;
    grant     = '0;
    gidx      = ptr;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found && slot_free && !reset) begin
      grant[gidx] = 1'b1;
    end
  end

  always_comb begin
    op      = bus.req_data[int'(gidx)*WIDTH +: WIDTH];
    sh      = bus.req_shamt[int'(gidx)*5 +: 5];
    ar      = bus.req_arith[gidx];
    shifted = ar ? WIDTH'($signed(op) >>> sh) : (op >> sh);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= EMPTY;
      ptr          <= '0;
      data_q       <= '0;
      id_q         <= '0;
      accept_count <= '0;
    end else begin
      if (|grant) begin
        state        <= FULL;
        data_q       <= shifted;
        id_q         <= gidx;
        ptr          <= gidx + 3'd1;
        accept_count <= accept_count + 16'd1;
      end else if (state == FULL && bus.resp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.req_ready  = grant;
  assign bus.resp_valid = (state == FULL);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb/tb_shift_arbiter.sv - scoreboard bench for shift_arbiter
module tb_shift_arbiter;
  logic        clk;
  logic        reset;
  logic [15:0] accept_count;

  shift_arbiter_if #(.WIDTH(32)) bus ();

  shift_arbiter #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .accept_count (accept_count)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  id;
    logic [15:0] c;
  } exp_t;

  exp_t        q[$];
  int          vectors;
  int          miscompares;
  logic [15:0] exp_count;
  logic [31:0] op_data[8];
  logic [4:0]  op_shamt[8];
  logic        op_arith[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent bit-serial reference for the shifter.
  function automatic logic [31:0] model(input logic [31:0] d, input int s, input logic a);
    logic [31:0] r;
    r = d;
    for (int j = 0; j < s; j++) r = {(a ? r[31] : 1'b0), r[31:1]};
    return r;
  endfunction

  task automatic set_op(input int i, input logic [31:0] d, input logic [4:0] s, input logic a);
    op_data[i]  = d;
    op_shamt[i] = s;
    op_arith[i] = a;
  endtask

  task automatic step(input logic [7:0] v, input logic rr, input logic [7:0] er,
                      input logic [31:0] ed, input logic [2:0] eid);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      bus.req_data[i*32 +: 32] = op_data[i];
      bus.req_shamt[i*5 +: 5]  = op_shamt[i];
      bus.req_arith[i]         = op_arith[i];
    end
    bus.req_valid  = v;
    bus.resp_ready = rr;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    if (er != 8'h00) begin
      exp_count = exp_count + 16'd1;
      q.push_back('{ed, eid, exp_count});
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    bus.req_valid = 8'h00;
    reset         = 1'b1;
    q.delete();
    exp_count     = 16'd0;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_count", 64'(accept_count), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: a result is consumed whenever valid and ready meet before an edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.resp_valid && bus.resp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'(bus.resp_id), 64'hFFFF);
        end else begin
          e = q.pop_front();
          chk("resp_data", 64'(bus.resp_data), 64'(e.d));
          chk("resp_id", 64'(bus.resp_id), 64'(e.id));
          chk("accept_count", 64'(accept_count), 64'(e.c));
        end
      end
    end
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    exp_count      = 16'd0;
    reset          = 1'b1;
    bus.req_valid  = 8'h00;
    bus.req_data   = '0;
    bus.req_shamt  = '0;
    bus.req_arith  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 8; i++) set_op(i, 32'h0, 5'd0, 1'b0);

    @(posedge clk);
    #1;
    bus.req_valid  = 8'hFF;
    bus.resp_ready = 1'b1;
    #1;
    chk("reset_req_ready", 64'(bus.req_ready), 64'd0);
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("reset_resp_data", 64'(bus.resp_data), 64'd0);
    chk("reset_resp_id", 64'(bus.resp_id), 64'd0);
    chk("reset_count", 64'(accept_count), 64'd0);
    bus.req_valid = 8'h00;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single arithmetic request from requester 2
    set_op(2, 32'h8000_0010, 5'd4, 1'b1);
    step(8'h04, 1'b1, 8'h04, 32'hF800_0001, 3'd2);
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);
    chk("single_valid", 64'(bus.resp_valid), 64'd1);
    chk("single_id", 64'(bus.resp_id), 64'd2);
    chk("single_count", 64'(accept_count), 64'd1);

    // Round robin from reset with all requesters active
    do_reset();
    for (int i = 0; i < 8; i++) set_op(i, 32'h8000_0000 | i, 5'(i), 1'(i % 2));
    for (int k = 0; k < 9; k++)
      step(8'hFF, 1'b1, 8'(1 << (k % 8)), model(32'h8000_0000 | (k % 8), k % 8, 1'(k % 2)), 3'(k % 8));
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);

    // Backpressure: result 3 held for five cycles, then requester 5 wins from ptr=4
    set_op(3, 32'h1234_5678, 5'd8, 1'b0);
    set_op(0, 32'hAAAA_0000, 5'd1, 1'b0);
    set_op(5, 32'h0000_FF00, 5'd4, 1'b0);
    step(8'h08, 1'b1, 8'h08, 32'h0012_3456, 3'd3);
    for (int k = 0; k < 5; k++) begin
      step(8'h21, 1'b0, 8'h00, 32'h0, 3'd0);
      chk("bp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_id", 64'(bus.resp_id), 64'd3);
      chk("bp_data", 64'(bus.resp_data), 64'h0012_3456);
    end
    step(8'h21, 1'b1, 8'h20, 32'h0000_0FF0, 3'd5);
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);
    chk("bp_next_id", 64'(bus.resp_id), 64'd5);

    // Logical versus arithmetic by 31
    set_op(6, 32'hF000_0000, 5'd31, 1'b0);
    step(8'h40, 1'b1, 8'h40, 32'h0000_0001, 3'd6);
    set_op(6, 32'hF000_0000, 5'd31, 1'b1);
    step(8'h40, 1'b1, 8'h40, 32'hFFFF_FFFF, 3'd6);
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);

    // Reset between edges while a result is held
    set_op(7, 32'h0000_0100, 5'd8, 1'b0);
    step(8'h04, 1'b0, 8'h04, 32'hF800_0001, 3'd2);
    do_reset();
    step(8'h80, 1'b1, 8'h80, 32'h0000_0001, 3'd7);
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);
    chk("post_rst_count", 64'(accept_count), 64'd1);

    // 65536 accepts bring the counter back to zero
    do_reset();
    for (int i = 0; i < 8; i++) set_op(i, 32'hC000_0000 + 32'(i), 5'(i), 1'b1);
    for (int k = 0; k < 65536; k++)
      step(8'hFF, 1'b1, 8'(1 << (k % 8)), model(32'hC000_0000 + 32'(k % 8), k % 8, 1'b1), 3'(k % 8));
    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);
    chk("wrap_count", 64'(accept_count), 64'd0);

    step(8'h00, 1'b1, 8'h00, 32'h0, 3'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
